// File: rtl/serial_alu_pkg.sv
// Shared ALU operation codes and small helpers for the execute-stage ALU.
package serial_alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] alu_ADD = 4'd0;
  localparam logic [ALU_OP_W-1:0] alu_SUB = 4'd1;
  localparam logic [ALU_OP_W-1:0] alu_AND = 4'd2;
  localparam logic [ALU_OP_W-1:0] alu_OR  = 4'd3;
  localparam logic [ALU_OP_W-1:0] alu_XOR = 4'd4;
  localparam logic [ALU_OP_W-1:0] alu_LLS = 4'd5;
  localparam logic [ALU_OP_W-1:0] alu_LRS = 4'd6;
  localparam logic [ALU_OP_W-1:0] alu_BEQ = 4'd7;
  localparam logic [ALU_OP_W-1:0] alu_BNE = 4'd8;
  localparam logic [ALU_OP_W-1:0] alu_BLT = 4'd9;
  localparam logic [ALU_OP_W-1:0] alu_BGE = 4'd10;

  // True for the two ops that go through the serial shifter.
  function automatic logic is_shift(input logic [ALU_OP_W-1:0] op);
    return (op == alu_LLS) || (op == alu_LRS);
  endfunction

endpackage

// File: rtl/serial_alu_single_cycle.sv
// Combinational single-cycle ALU: logic, add/sub and branch compares.
module alu_single_cycle
  import serial_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     a,
  input  logic [XLEN-1:0]     b,
  output logic [XLEN-1:0]     result,
  output logic                bcond
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  // Decode the op; branch ops produce a zero result and only drive bcond.
  always_comb begin
    result = '0;
    bcond  = 1'b0;
    case (alu_op)
      alu_ADD: result = a + b;
      alu_SUB: result = a - b;
      alu_AND: result = a & b;
      alu_OR:  result = a | b;
      alu_XOR: result = a ^ b;
      alu_BEQ: bcond  = (a == b);
      alu_BNE: bcond  = (a != b);
      alu_BLT: bcond  = (a_s < b_s);
      alu_BGE: bcond  = (a_s >= b_s);
      default: begin
        result = '0;
        bcond  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Execute-stage ALU with valid/ready handshake; single-cycle ops plus a
// one-bit-per-cycle serial shifter that stalls the input while busy.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] alu_op,
  input  logic [XLEN-1:0]     in_a,
  input  logic [XLEN-1:0]     in_b,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     alu_result,
  output logic                alu_bcond
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

  logic [1:0]         state_q,     state_d;
  logic [XLEN-1:0]    shreg_q,     shreg_d;
  logic [SHAMT_W-1:0] cnt_q,       cnt_d;
  logic               dir_right_q, dir_right_d;
  logic [XLEN-1:0]    result_q,    result_d;
  logic               bcond_q,     bcond_d;
  logic               out_valid_q, out_valid_d;

  logic [XLEN-1:0]    sc_result;
  logic               sc_bcond;
  logic [XLEN-1:0]    shifted;
  logic [SHAMT_W-1:0] shamt;
  logic               accept;

  alu_single_cycle #(.XLEN(XLEN)) u_sc (
    .alu_op (alu_op),
    .a      (in_a),
    .b      (in_b),
    .result (sc_result),
    .bcond  (sc_bcond)
  );

  assign shamt    = in_b[SHAMT_W-1:0];
  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign shifted  = dir_right_q ? (shreg_q >> 1) : (shreg_q << 1);

  // Next-state logic: flush overrides everything, DONE with out_ready
  // behaves as IDLE so a back-to-back accept needs no bubble.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    result_d    = result_q;
    bcond_d     = bcond_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if ((state_q == ST_DONE) && out_ready) begin
            state_d = ST_IDLE;
          end
          if (accept) begin
            if (is_shift(alu_op)) begin
              shreg_d     = in_a;
              cnt_d       = shamt;
              dir_right_d = (alu_op == alu_LRS);
              if (shamt == '0) begin
                result_d = in_a;
                bcond_d  = 1'b0;
                state_d  = ST_DONE;
              end else begin
                state_d  = ST_SHIFT;
              end
            end else begin
              result_d = sc_result;
              bcond_d  = sc_bcond;
              state_d  = ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          shreg_d = shifted;
          cnt_d   = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            result_d = shifted;
            bcond_d  = 1'b0;
            state_d  = ST_DONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    out_valid_d = (state_d == ST_DONE);
  end

  // State, shifter, counter and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      result_q    <= '0;
      bcond_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      result_q    <= result_d;
      bcond_q     <= bcond_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_result = result_q;
  assign alu_bcond  = bcond_q;

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu with a behavioural reference model.
module tb_serial_alu;
  import serial_alu_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      alu_op = 4'd0;
  logic [XLEN-1:0] in_a = '0;
  logic [XLEN-1:0] in_b = '0;
  logic            flush = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [XLEN-1:0] alu_result;
  logic            alu_bcond;

  int n_checks = 0;
  int n_fail   = 0;

  serial_alu #(.XLEN(XLEN), .SHAMT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_op     (alu_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_result (alu_result),
    .alu_bcond  (alu_bcond)
  );

  always #5 clk = ~clk;

  // Reference: what the op computes and how many cycles after the accept
  // edge the result becomes valid.
  function automatic void model(input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] r,
                                output logic bc, output int lat);
    int k;
    k   = int'(b % 32);
    r   = 32'd0;
    bc  = 1'b0;
    lat = 1;
    if (op == alu_ADD) r = a + b;
    else if (op == alu_SUB) r = a - b;
    else if (op == alu_AND) r = a & b;
    else if (op == alu_OR)  r = a | b;
    else if (op == alu_XOR) r = a ^ b;
    else if (op == alu_BEQ) bc = (a == b);
    else if (op == alu_BNE) bc = (a != b);
    else if (op == alu_BLT) bc = ($signed(a) < $signed(b));
    else if (op == alu_BGE) bc = ($signed(a) >= $signed(b));
    else if (op == alu_LLS || op == alu_LRS) begin
      r   = (op == alu_LLS) ? (a << k) : (a >> k);
      lat = (k == 0) ? 1 : k + 1;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an op, wait for its result, check value/latency/stall, then consume it.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        eb;
    int          lat, c, low, w;
    model(op, a, b, er, eb, lat);
    w = 0;
    while (!in_ready && w < 100) begin
      tick();
      w++;
    end
    alu_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 1; low = 0;
    while (!out_valid && c < 100) begin
      if (!in_ready) low++;
      tick();
      c++;
    end
    n_checks++;
    if (c !== lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d expected %0d", name, c, lat);
    end
    n_checks++;
    if (alu_result !== er || alu_bcond !== eb) begin
      n_fail++;
      $display("FAIL %s result: got %h/%b expected %h/%b", name, alu_result, alu_bcond, er, eb);
    end
    n_checks++;
    if (low !== lat - 1) begin
      n_fail++;
      $display("FAIL %s stall: in_ready low %0d cycles expected %0d", name, low, lat - 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'd0 || alu_bcond !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%h b=%b rdy=%b expected 0/0/0/1",
               out_valid, alu_result, alu_bcond, in_ready);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op("add_wrap", alu_ADD, 32'hFFFF_FFFF, 32'd1);
    run_op("blt_neg",  alu_BLT, 32'hFFFF_FFFE, 32'd1);
    run_op("bge_neg",  alu_BGE, 32'hFFFF_FFFE, 32'd1);
    run_op("bne_eq",   alu_BNE, 32'd5, 32'd5);
    run_op("beq_eq",   alu_BEQ, 32'd5, 32'd5);
    run_op("sub",      alu_SUB, 32'd3, 32'd10);
    run_op("unlisted", 4'd13, 32'h1234_5678, 32'h1);
  endtask

  task automatic test_shift();
    run_op("lls_31",   alu_LLS, 32'h0000_0001, 32'd31);
    run_op("lrs_4",    alu_LRS, 32'h8000_0000, 32'd4);
    run_op("lls_0x20", alu_LLS, 32'hDEAD_BEEF, 32'h20);
    run_op("lrs_1",    alu_LRS, 32'hF000_000F, 32'd1);
  endtask

  // Hold the result in DONE, then hand over directly to a new XOR.
  task automatic test_back_to_back();
    logic [31:0] held;
    alu_op = alu_OR; in_a = 32'h00F0_0000; in_b = 32'h0000_000F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    held = 32'h00F0_000F;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || alu_result !== held || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_done[%0d]: got v=%b r=%h rdy=%b expected 1/%h/0",
                 i, out_valid, alu_result, in_ready, held);
      end
      tick();
    end
    out_ready = 1'b1;
    alu_op = alu_XOR; in_a = 32'hA5A5_A5A5; in_b = 32'hFFFF_0000; in_valid = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b expected 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || alu_result !== 32'h5A5A_A5A5) begin
      n_fail++;
      $display("FAIL b2b_xor: got v=%b r=%h expected 1/5a5aa5a5", out_valid, alu_result);
    end
    // Streaming ADDs at one per cycle with out_ready held high.
    for (int i = 0; i < 4; i++) begin
      alu_op = alu_ADD; in_a = 32'(i * 100); in_b = 32'd7; in_valid = 1'b1;
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || alu_result !== 32'(i * 100 + 7)) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b r=%h expected 1/%h", i, out_valid, alu_result, 32'(i * 100 + 7));
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_idle: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_flush();
    alu_op = alu_LLS; in_a = 32'h1; in_b = 32'd20; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_shift: got v=%b rdy=%b expected 0/1", out_valid, in_ready);
    end
    // An accept coincident with flush must be dropped.
    flush = 1'b1;
    alu_op = alu_ADD; in_a = 32'd1; in_b = 32'd2; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_accept: got out_valid %b expected 0", out_valid);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_accept_late: got out_valid %b expected 0", out_valid);
    end
    run_op("after_flush", alu_LRS, 32'hFF00_0000, 32'd8);
  endtask

  task automatic test_reset_midshift();
    alu_op = alu_LRS; in_a = 32'hFFFF_FFFF; in_b = 32'd25; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || alu_result !== 32'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midshift: got v=%b r=%h rdy=%b expected 0/0/1", out_valid, alu_result, in_ready);
    end
    #1 reset = 1'b1;
    tick();
    run_op("after_reset", alu_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 4 == 0) ? a : $urandom;
      run_op($sformatf("rand%0d", i), op, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_shift();
    test_back_to_back();
    test_flush();
    test_reset_midshift();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
